touch_spi_scan_master: RTL
==========================

Name: touch_spi_scan_master

Overview:
Parametrised SPI master for the resistive-touch controller, succeeding the fixed 8-bit-command / 16-bit-response master.
- Command width, response width and SCK rate are parameters.
- Adds an autonomous scan mode that walks a table of NUM_CH commands (e.g. X, Y, Z1, Z2) whenever the pen-down IRQ is active.
- Results are tagged with a channel index.
- Sits between the touch panel pins and the coordinate-filter logic.

Parameters:
CMD_W, 8, command bits shifted out per transaction (1..16)
RESP_W, 16, response bits shifted in per transaction (1..24)
SCK_DIV, 1, clk_1MHz cycles per SCK half-period (>=1)
NUM_CH, 4, command slots in scan table (1..8); CH_W = max(1, clog2(NUM_CH)) is derived

Ports:
clk_1MHz  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
start  in  1  single-shot request using cmd_in; sampled in IDLE only
cmd_in  in  CMD_W  command for single-shot transaction
scan_en  in  1  enables autonomous scan
scan_cmds  in  NUM_CH*CMD_W  scan table; slot k = bits [k*CMD_W +: CMD_W]
i_irq  in  1  pen IRQ from controller, active-low
i_sdo  in  1  serial data from controller
o_cs  out  1  chip select, active-low
o_sck  out  1  serial clock, idle low
o_sdi  out  1  serial data to controller
busy  out  1  high from accept until return to IDLE
data_out  out  RESP_W  last received word, held until next data_valid
data_ch  out  CH_W  slot of data_out (0 for single-shot)
data_valid  out  1  one-cycle pulse per completed transaction
scan_done  out  1  one-cycle pulse after the last slot of a complete scan

Behaviour:
- Reset (async, any state): o_cs=1, o_sck=0, o_sdi=0, busy=0, data_out=0, data_ch=0, data_valid=0, scan_done=0, state IDLE, divider=0, slot=0.
- SPI mode 0, MSB first both directions.
  - o_sdi changes only while o_sck is low.
  - i_sdo is sampled on the clk edge that drives o_sck high.
  - o_sck is forced 0 whenever o_cs=1.
- Half-period tick: divider counts 0..SCK_DIV-1 and ticks at SCK_DIV-1. It is cleared in IDLE and CSGAP.
- States: IDLE, SETUP, SEND, GAP, RECV, DONE, CSGAP.
- IDLE:
  - start=1: latch cmd_in, slot=0, mode single.
  - Else scan_en=1 and irq low: latch slot 0 of scan_cmds, mode scan.
  - start has priority when both request on the same edge.
  - On the accepting edge: o_cs->0, busy->1, o_sdi->command MSB; go to SETUP.
- SETUP: one half-period with sck low, then SEND.
- SEND: CMD_W full SCK periods (rise tick, fall tick); the next bit is presented on each fall tick. After the last fall tick go to GAP.
- GAP: one half-period, sck low, o_sdi=0; this absorbs the controller's busy bit. Then RECV.
- RECV: RESP_W periods; shift i_sdo in at each rise tick. After the last fall tick go to DONE.
- DONE, one cycle:
  - data_out <= shift reg, data_ch <= slot, data_valid=1, o_cs->1.
  - Single mode, or scan mode on the last slot or with scan_en=0: go to IDLE with busy->0. In scan mode on the last slot with scan_en=1, scan_done=1 in the same cycle.
  - Otherwise go to CSGAP.
- CSGAP: o_cs held high for 2*SCK_DIV cycles, slot+1, load next command, re-enter SETUP with o_cs->0. busy stays 1.
- Latency: accept edge E -> data_valid high after edge E + 2*SCK_DIV*(CMD_W+RESP_W+1) + 1. Defaults: 51.
- i_irq is evaluated only in IDLE. The controller toggles IRQ during conversion, so it is ignored mid-scan.
- scan_en dropping mid-scan: the current transaction completes normally, remaining slots are skipped, and there is no scan_done.
- start while busy is ignored and not queued.
- cmd_in and scan_cmds are captured per transaction; changes mid-transaction have no effect.
- Scan is continuous: IDLE re-evaluates on the cycle after busy falls.

Optional Feature:
TOUCH_SPI_IRQ_SYNC_EN
- Defined: i_irq and i_sdo each pass through a 2-flop synchroniser reset to 1/0. Scan start is delayed 2 cycles after i_irq falls. sdo sampling uses the synchronised value, which requires SCK_DIV>=3.
- Undefined: raw inputs are used directly. Timing is exactly as above.

Test Plan:
- Defaults, start=1 one cycle, cmd_in=8'h93, controller returns 16'hA5C3 -> o_sdi bit stream 1,0,0,1,0,0,1,1 on rise edges; data_valid at edge 51; data_out=16'hA5C3, data_ch=0, busy low next cycle.
- SCK_DIV=3, CMD_W=8, RESP_W=12 -> o_sck half-period exactly 3 cycles; data_valid at edge 2*3*21+1=127; data_out=12'hFFF with i_sdo tied high.
- scan_en=1, i_irq=0, scan_cmds={D0,90,B0,C0}, slot responses 1,2,3,4 -> four data_valid pulses (data_ch 0..3, data 1..4); o_cs high 2 cycles between transactions; scan_done coincident with the 4th data_valid.
- Mid-scan: drop scan_en during slot 1 -> slot 1 data_valid occurs; no slot 2 or 3; scan_done stays 0; busy falls after slot 1 DONE.
- start and scan request in the same IDLE cycle -> single-shot runs first with data_ch=0; the scan begins after busy falls.
- rst_n pulsed low during RECV -> o_cs=1, o_sck=0, data_valid=0 asynchronously; data_out=0; a fresh start after release completes normally.

Source files
------------

// File: rtl/touch_spi_scan_master.sv
// Parametrised SPI mode-0 master for a resistive-touch controller with pen-IRQ driven scan table.
// Define TOUCH_SPI_IRQ_SYNC_EN to pass i_irq/i_sdo through 2-flop synchronisers (needs SCK_DIV>=3).
module touch_spi_scan_master #(
    parameter int CMD_W   = 8,
    parameter int RESP_W  = 16,
    parameter int SCK_DIV = 1,
    parameter int NUM_CH  = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk_1MHz,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CMD_W-1:0]        cmd_in,
    input  logic                    scan_en,
    input  logic [NUM_CH*CMD_W-1:0] scan_cmds,
    input  logic                    i_irq,
    input  logic                    i_sdo,
    output logic                    o_cs,
    output logic                    o_sck,
    output logic                    o_sdi,
    output logic                    busy,
    output logic [RESP_W-1:0]       data_out,
    output logic [CH_W-1:0]         data_ch,
    output logic                    data_valid,
    output logic                    scan_done
);
    localparam int DIV_W    = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int BITS_MAX = (CMD_W > RESP_W) ? CMD_W : RESP_W;
    localparam int CNT_MAX  = (BITS_MAX > 2 * SCK_DIV) ? BITS_MAX : 2 * SCK_DIV;
    localparam int CNT_W    = $clog2(CNT_MAX);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCK_DIV - 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * SCK_DIV - 1);
    localparam logic [CH_W-1:0]  SLOT_LAST = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StSend, StGap, StRecv, StDone, StCsGap} state_t;

    state_t            state;
    logic [DIV_W-1:0]  div;
    logic [CNT_W-1:0]  cnt;
    logic [CH_W-1:0]   slot;
    logic              scan_mode;
    logic [CMD_W-1:0]  tx;
    logic [RESP_W-1:0] rx;
    logic              tick;
    logic [CMD_W-1:0]  tx_shift;
    logic [CH_W-1:0]   next_slot;
    logic [CMD_W-1:0]  next_cmd;
    logic              irq_use;
    logic              sdo_use;

`ifdef TOUCH_SPI_IRQ_SYNC_EN
    logic [1:0] irq_sync;
    logic [1:0] sdo_sync;

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            irq_sync <= 2'b11;
            sdo_sync <= 2'b00;
        end else begin
            irq_sync <= {irq_sync[0], i_irq};
            sdo_sync <= {sdo_sync[0], i_sdo};
        end
    end

    assign irq_use = irq_sync[1];
    assign sdo_use = sdo_sync[1];
`else
    assign irq_use = i_irq;
    assign sdo_use = i_sdo;
`endif

    assign tick      = (div == DIV_LAST);
    assign tx_shift  = tx << 1;
    assign next_slot = slot + CH_W'(1);
    assign next_cmd  = scan_cmds[int'(next_slot) * CMD_W +: CMD_W];

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            div        <= '0;
            cnt        <= '0;
            slot       <= '0;
            scan_mode  <= 1'b0;
            tx         <= '0;
            rx         <= '0;
            o_cs       <= 1'b1;
            o_sck      <= 1'b0;
            o_sdi      <= 1'b0;
            busy       <= 1'b0;
            data_out   <= '0;
            data_ch    <= '0;
            data_valid <= 1'b0;
            scan_done  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            scan_done  <= 1'b0;
            if (state == StIdle || state == StCsGap || tick) begin
                div <= '0;
            end else begin
                div <= div + DIV_W'(1);
            end

            unique case (state)
                StIdle: begin
                    // start wins over a simultaneous scan request
                    if (start || (scan_en && !irq_use)) begin
                        tx        <= start ? cmd_in : scan_cmds[CMD_W-1:0];
                        o_sdi     <= start ? cmd_in[CMD_W-1] : scan_cmds[CMD_W-1];
                        scan_mode <= !start;
                        slot      <= '0;
                        o_cs      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= StSetup;
                    end
                end
                StSetup: begin
                    if (tick) begin
                        cnt   <= '0;
                        state <= StSend;
                    end
                end
                StSend: begin
                    if (tick) begin
                        if (!o_sck) begin
                            o_sck <= 1'b1;
                        end else begin
                            o_sck <= 1'b0;
                            if (cnt == CMD_LAST) begin
                                o_sdi <= 1'b0;
                                state <= StGap;
                            end else begin
                                cnt   <= cnt + CNT_W'(1);
                                tx    <= tx_shift;
                                o_sdi <= tx_shift[CMD_W-1];
                            end
                        end
                    end
                end
                StGap: begin
                    // swallows the controller's busy bit
                    if (tick) begin
                        cnt   <= '0;
                        state <= StRecv;
                    end
                end
                StRecv: begin
                    if (tick) begin
                        if (!o_sck) begin
                            o_sck <= 1'b1;
                            rx    <= (rx << 1) | RESP_W'(sdo_use);
                        end else begin
                            o_sck <= 1'b0;
                            if (cnt == RESP_LAST) begin
                                state <= StDone;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                StDone: begin
                    data_out   <= rx;
                    data_ch    <= slot;
                    data_valid <= 1'b1;
                    o_cs       <= 1'b1;
                    if (scan_mode && scan_en && slot != SLOT_LAST) begin
                        cnt   <= '0;
                        state <= StCsGap;
                    end else begin
                        busy      <= 1'b0;
                        scan_done <= scan_mode && scan_en;
                        state     <= StIdle;
                    end
                end
                StCsGap: begin
                    if (cnt == GAP_LAST) begin
                        slot  <= next_slot;
                        tx    <= next_cmd;
                        o_sdi <= next_cmd[CMD_W-1];
                        o_cs  <= 1'b0;
                        state <= StSetup;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule
